// File: rtl/module_basis_index_search_pkg.sv
// Shared constants for the basis-index search: FSM state codes and list depth helper.
package module_basis_index_search_pkg;

  localparam int unsigned DefaultNumQubit = 4;

  function automatic int unsigned list_depth(input int unsigned nq);
    return 32'd1 << nq;
  endfunction

  localparam int unsigned ListDepth = list_depth(DefaultNumQubit);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/module_basis_compare.sv
// Masked equality of two basis indices; a cleared mask bit is a don't-care.
module module_basis_compare #(
  parameter int unsigned num_qubit = 4
) (
  input  logic a    [0:num_qubit-1],
  input  logic b    [0:num_qubit-1],
  input  logic mask [0:num_qubit-1],
  output logic eq
);

  always_comb begin
    eq = 1'b1;
    for (int unsigned i = 0; i < num_qubit; i++) begin
      if (mask[i] && (a[i] != b[i])) begin
        eq = 1'b0;
      end
    end
  end

endmodule

// File: rtl/module_basis_index_search.sv
// Scans a rotating basis-index list by strobing one full rotation and records the first
// match position and the total match count among the valid entries.
module module_basis_index_search
  import module_basis_index_search_pkg::*;
#(
  parameter int unsigned num_qubit = DefaultNumQubit
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        target_index          [0:num_qubit-1],
  input  logic        compare_mask          [0:num_qubit-1],
  input  logic [31:0] num_entries,
  input  logic        basis_index2_leftmost [0:num_qubit-1],
  output logic        rotate_req,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] match_pos,
  output logic [31:0] match_count
);

  localparam int unsigned Depth = list_depth(num_qubit);
  localparam int unsigned CntW  = num_qubit + 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
  localparam logic [CntW-1:0] LastPos = CntW'(Depth - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] pos_q, pos_d;
  logic [CntW-1:0] n_ent_q, n_ent_d;
  logic [CntW-1:0] mpos_q, mpos_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            found_q, found_d;
  logic            tgt_q  [0:num_qubit-1];
  logic            tgt_d  [0:num_qubit-1];
  logic            mask_q [0:num_qubit-1];
  logic            mask_d [0:num_qubit-1];
  logic [CntW-1:0] n_ent_clamp;
  logic            eq;
  logic            hit;

  assign n_ent_clamp = (num_entries > 32'(Depth)) ? DepthC : num_entries[CntW-1:0];

  module_basis_compare #(
    .num_qubit(num_qubit)
  ) u_compare (
    .a   (basis_index2_leftmost),
    .b   (tgt_q),
    .mask(mask_q),
    .eq  (eq)
  );

  // The head seen during SCAN cycle k is list entry k, since each cycle rotates once.
  assign hit = (state_q == StScan) && (pos_q < n_ent_q) && eq;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    n_ent_d = n_ent_q;
    mpos_d  = mpos_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    tgt_d   = tgt_q;
    mask_d  = mask_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          pos_d   = '0;
          n_ent_d = n_ent_clamp;
          mpos_d  = '0;
          cnt_d   = '0;
          found_d = 1'b0;
          tgt_d   = target_index;
          mask_d  = compare_mask;
        end
      end
      StScan: begin
        if (hit) begin
          if (!found_q) begin
            found_d = 1'b1;
            mpos_d  = pos_q;
          end
          if (cnt_q != DepthC) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        pos_d = pos_q + CntW'(1);
        if (pos_q == LastPos) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        pos_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pos_q   <= '0;
      n_ent_q <= '0;
      mpos_q  <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      tgt_q   <= '{default: 1'b0};
      mask_q  <= '{default: 1'b0};
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      n_ent_q <= n_ent_d;
      mpos_q  <= mpos_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      tgt_q   <= tgt_d;
      mask_q  <= mask_d;
    end
  end

  assign rotate_req  = (state_q == StScan);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign found       = found_q;
  assign match_pos   = 32'(mpos_q);
  assign match_count = 32'(cnt_q);

endmodule
